sang_chay_param: RTL and testbench

Parametrised running-light controller for the LED kit: one block that combines a programmable step-rate divider with a multi-mode LED pattern engine. It drives a `WIDTH`-bit LED bank directly from the board clock and replaces the fixed 8-LED, fixed-rate, single-pattern shifter pair. It adds four selectable patterns, a runtime speed select, pause, and a step strobe for chaining or debug.

---
 rtl/led_pkg.sv | 17 +
 rtl/sang_chay_param_if.sv | 13 +
 rtl/chia_xung_param.sv | 35 +++
 rtl/sang_chay_param.sv | 92 +++++++++
 tb/tb_sang_chay_param.sv | 122 ++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the running-light controller: pattern modes and
// ping-pong direction.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROL  = 2'd0,
    MODE_ROR  = 2'd1,
    MODE_PING = 2'd2,
    MODE_BAR  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/sang_chay_param_if.sv
// Control and LED bus of the running-light controller.
interface sang_chay_param_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic             pause;
  logic [WIDTH-1:0] led;
  logic             tick;

  modport master (output mode, output speed, output pause, input led, input tick);
  modport slave  (input mode, input speed, input pause, output led, output tick);
endinterface

// File: rtl/chia_xung_param.sv
// Step-rate divider: one-cycle step_en every (DIV >> speed) clocks, frozen
// while pause is high.
module chia_xung_param #(
  parameter int DIV = 50_000_000
) (
  input  logic       clki,
  input  logic       rs,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic       step_en
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [31:0]   len;
  logic [31:0]   cnt_ext;
  logic          hit;

  assign len     = 32'(DIV) >> speed;
  assign cnt_ext = 32'(cnt);
  // >= rather than == so a speed-up that leaves cnt beyond the new limit
  // fires on the next edge instead of running the counter around.
  assign hit     = (cnt_ext >= (len - 32'd1));
  assign step_en = hit & ~pause;

  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= hit ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sang_chay_param.sv
// Running-light controller: divider-driven multi-mode LED pattern engine
// with pause, runtime speed select and a per-step tick.
module sang_chay_param
  import led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 50_000_000
) (
  input  logic             clki,
  input  logic             rs,
  sang_chay_param_if.slave bus
);

  logic             step_en;
  logic [WIDTH-1:0] led_q, led_d;
  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic             tick_q;
  mode_e            mode_in;

  chia_xung_param #(.DIV(DIV)) u_div (
    .clki    (clki),
    .rs      (rs),
    .speed   (bus.speed),
    .pause   (bus.pause),
    .step_en (step_en)
  );

  assign mode_in = mode_e'(bus.mode);

  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      led_q  <= WIDTH'(1);
      mode_q <= MODE_ROL;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      tick_q <= step_en;
    end
  end

  always_comb begin
    led_d  = led_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    if (step_en) begin
      if (mode_in != mode_q) begin
        // A mode change only reloads the start pattern; shifting resumes next step.
        mode_d = mode_in;
        dir_d  = DIR_UP;
        case (mode_in)
          MODE_ROL:  led_d = WIDTH'(1);
          MODE_ROR:  led_d = {1'b1, {(WIDTH-1){1'b0}}};
          MODE_PING: led_d = WIDTH'(1);
          MODE_BAR:  led_d = '0;
          default:   led_d = WIDTH'(1);
        endcase
      end else begin
        case (mode_q)
          MODE_ROL:  led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          MODE_ROR:  led_d = {led_q[0], led_q[WIDTH-1:1]};
          MODE_PING: begin
            if (dir_q == DIR_UP) begin
              if (led_q[WIDTH-1]) begin
                dir_d = DIR_DOWN;
                led_d = led_q >> 1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                dir_d = DIR_UP;
                led_d = led_q << 1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          MODE_BAR:  led_d = (&led_q) ? '0 : {led_q[WIDTH-2:0], 1'b1};
          default:   led_d = led_q;
        endcase
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_sang_chay_param.sv
// Directed bench for sang_chay_param with WIDTH=8, DIV=8.
module tb_sang_chay_param;

  localparam int WIDTH = 8;
  localparam int DIV   = 8;

  logic clki = 1'b0;
  logic rs   = 1'b0;

  sang_chay_param_if #(.WIDTH(WIDTH)) bus ();

  sang_chay_param #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clki (clki),
    .rs   (rs),
    .bus  (bus.slave)
  );

  always #5 clki = ~clki;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rol_seq [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bar_seq [12] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                               8'hFF, 8'h00, 8'h01, 8'h03};
  logic [7:0] png_seq [23] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                               8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts falling edges until tick is seen; 64 means it never came.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clki);
      n++;
    end while (!bus.tick && n < 64);
  endtask

  task automatic step_chk(input string tag, input int exp_n, input logic [7:0] exp_led);
    int n;
    wait_tick(n);
    chk({tag, "_gap"}, 32'(n), 32'(exp_n));
    chk({tag, "_led"}, 32'(bus.led), 32'(exp_led));
  endtask

  initial begin
    logic seen;
    bus.mode  = 2'd0;
    bus.speed = 2'd0;
    bus.pause = 1'b0;

    #12;
    chk("rst_led", 32'(bus.led), 32'h01);
    chk("rst_tick", 32'(bus.tick), 32'h0);
    @(negedge clki);
    rs = 1'b1;

    for (int i = 0; i < 8; i++) step_chk($sformatf("rol%0d", i), 8, rol_seq[i]);

    bus.mode = 2'd3;
    for (int i = 0; i < 12; i++) step_chk($sformatf("bar%0d", i), 8, bar_seq[i]);

    bus.mode = 2'd1;
    step_chk("ror_load", 8, 8'h80);
    step_chk("ror_1", 8, 8'h40);

    // cnt reaches 5, then speed jumps to x8 (L=1)
    repeat (5) @(negedge clki);
    bus.speed = 2'd3;
    step_chk("spd_a", 1, 8'h20);
    step_chk("spd_b", 1, 8'h10);
    bus.speed = 2'd0;
    step_chk("spd_c", 8, 8'h08);

    repeat (3) @(negedge clki);
    bus.pause = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clki);
      if (bus.tick) seen = 1'b1;
    end
    chk("pause_tick", 32'(seen), 32'h0);
    chk("pause_led", 32'(bus.led), 32'h08);
    bus.pause = 1'b0;
    step_chk("pause_res", 5, 8'h04);

    // pause raised exactly when cnt sits at L-1
    repeat (7) @(negedge clki);
    bus.pause = 1'b1;
    @(negedge clki);
    chk("pwin_tick", 32'(bus.tick), 32'h0);
    chk("pwin_led", 32'(bus.led), 32'h04);
    bus.pause = 1'b0;
    step_chk("pwin_res", 1, 8'h02);

    bus.mode = 2'd2;
    for (int i = 0; i < 23; i++) step_chk($sformatf("png%0d", i), 8, png_seq[i]);

    // ping-pong is heading down from 0x40 with tick high; reset mid-cycle
    #3;
    rs = 1'b0;
    #1;
    chk("arst_led", 32'(bus.led), 32'h01);
    chk("arst_tick", 32'(bus.tick), 32'h0);
    @(negedge clki);
    rs = 1'b1;
    step_chk("post_rst_load", 8, 8'h01);
    step_chk("post_rst", 8, 8'h02);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
